// File: rtl/hh_stim_sequencer.sv
// hh_stim_sequencer: drives the HH core with a programmable train of current pulses and counts the spikes it emits
module hh_stim_sequencer #(
  parameter int PRESCALE = 256
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cfg_valid,
  output logic       cfg_ready,
  input  logic [1:0] cfg_addr,
  input  logic [7:0] cfg_data,
  input  logic       start,
  input  logic       abort,
  input  logic       spike_in,
  output logic [7:0] stim_current,
  output logic       busy,
  output logic       done,
  output logic [7:0] pulse_idx,
  output logic [7:0] spike_count
);
  localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);
  typedef enum logic [1:0] {IDLE, ON, OFF, DONE} state_t;
  state_t r_state, w_next;
  logic [7:0] r_amp, r_on, r_off, r_n, r_idx, r_cnt, r_step;
  logic [PW-1:0] r_pre;
  logic r_spk_d;
  logic w_busy, w_step_end, w_phase_end, w_last, w_inc, w_clr, w_tclr;
  logic [7:0] w_len;
  assign w_busy = r_state == ON || r_state == OFF;
  assign w_len = r_state == ON ? r_on : r_off;
  assign w_step_end = r_pre == PRE_MAX;
  assign w_phase_end = w_step_end && r_step == w_len - 8'd1;
  assign w_last = r_idx == r_n - 8'd1;
  // timers restart on every phase entry, including ON->ON when OFF_LEN is zero
  assign w_tclr = !w_busy || w_phase_end || w_next != r_state;
  always_comb begin
    w_next = r_state;
    w_inc = 1'b0;
    w_clr = 1'b0;
    case (r_state)
      IDLE: if (start) begin
        w_clr = 1'b1;
        w_next = (r_n == 8'd0 || r_on == 8'd0) ? DONE : ON;
      end
      ON: if (w_phase_end) begin
        w_next = r_off != 8'd0 ? OFF : w_last ? DONE : ON;
        w_inc = r_off == 8'd0 && !w_last;
      end
      OFF: if (w_phase_end) begin
        w_next = w_last ? DONE : ON;
        w_inc = !w_last;
      end
      default: w_next = IDLE;
    endcase
    if (abort) begin
      w_next = IDLE;
      w_inc = 1'b0;
      w_clr = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_amp <= '0;
      r_on <= '0;
      r_off <= '0;
      r_n <= '0;
      r_idx <= '0;
      r_cnt <= '0;
      r_step <= '0;
      r_pre <= '0;
      r_spk_d <= 1'b0;
    end else begin
      r_state <= w_next;
      r_spk_d <= spike_in;
      if (cfg_valid && cfg_ready) begin
        case (cfg_addr)
          2'd0: r_amp <= cfg_data;
          2'd1: r_on <= cfg_data;
          2'd2: r_off <= cfg_data;
          default: r_n <= cfg_data;
        endcase
      end
      r_pre <= (w_tclr || w_step_end) ? '0 : r_pre + 1'b1;
      r_step <= w_tclr ? '0 : r_step + 8'(w_step_end);
      if (w_clr) begin
        r_idx <= '0;
        r_cnt <= '0;
      end else begin
        if (w_inc) r_idx <= r_idx + 8'd1;
        if (w_busy && spike_in && !r_spk_d && r_cnt != 8'hFF) r_cnt <= r_cnt + 8'd1;
      end
    end
  end
  assign cfg_ready = r_state == IDLE;
  assign busy = w_busy;
  assign done = r_state == DONE;
  assign stim_current = r_state == ON ? r_amp : 8'd0;
  assign pulse_idx = r_idx;
  assign spike_count = r_cnt;
endmodule

// File: tb/tb_hh_stim_sequencer.sv
// tb_hh_stim_sequencer: randomized runs checked cycle by cycle against an expected per-cycle timeline
module tb_hh_stim_sequencer;
  localparam int P = 4;
  logic clk = 1'b0, rst_n = 1'b0, cfg_valid = 1'b0, start = 1'b0, abort = 1'b0, spike_in = 1'b0;
  logic [1:0] cfg_addr = '0;
  logic [7:0] cfg_data = '0;
  logic cfg_ready, busy, done;
  logic [7:0] stim_current, pulse_idx, spike_count;
  int total = 0, bad = 0;
  logic [7:0] m_amp = '0, m_on = '0, m_off = '0, m_n = '0;
  typedef struct {
    logic [7:0] stim;
    logic       busy;
    logic [7:0] idx;
    logic       done;
  } ent_t;
  ent_t tl[$];

  hh_stim_sequencer #(.PRESCALE(P)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_addr(cfg_addr), .cfg_data(cfg_data), .start(start), .abort(abort),
    .spike_in(spike_in), .stim_current(stim_current), .busy(busy), .done(done),
    .pulse_idx(pulse_idx), .spike_count(spike_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    chk("ready_idle", 32'(cfg_ready), 32'd1);
    cfg_valid = 1'b1;
    cfg_addr = a;
    cfg_data = d;
    tick;
    cfg_valid = 1'b0;
    case (a)
      2'd0: m_amp = d;
      2'd1: m_on = d;
      2'd2: m_off = d;
      default: m_n = d;
    endcase
  endtask

  // one entry per cycle after start: pulses of ON*P then OFF*P cycles, then the done cycle
  task automatic build;
    logic [7:0] lp;
    tl.delete();
    lp = 8'd0;
    if (m_n != 0 && m_on != 0) begin
      for (int p = 0; p < int'(m_n); p++) begin
        for (int c = 0; c < int'(m_on) * P; c++) tl.push_back('{m_amp, 1'b1, 8'(p), 1'b0});
        for (int c = 0; c < int'(m_off) * P; c++) tl.push_back('{8'd0, 1'b1, 8'(p), 1'b0});
      end
      lp = m_n - 8'd1;
    end
    tl.push_back('{8'd0, 1'b0, lp, 1'b1});
  endtask

  task automatic idle_chk(input logic [7:0] idx, input int cnt, input string tag);
    chk({tag, "_stim"}, 32'(stim_current), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_pidx"}, 32'(pulse_idx), 32'(idx));
    chk({tag, "_spk"}, 32'(spike_count), 32'(cnt));
    chk({tag, "_ready"}, 32'(cfg_ready), 32'd1);
  endtask

  task automatic run(input int mode, input int abort_at);
    int cnt;
    logic prev;
    logic [7:0] lidx;
    cnt = 0;
    build;
    spike_in = 1'($urandom % 2);
    prev = spike_in;
    start = 1'b1;
    tick;
    start = 1'b0;
    lidx = 8'd0;
    for (int i = 0; i < tl.size(); i++) begin
      chk("stim", 32'(stim_current), 32'(tl[i].stim));
      chk("busy", 32'(busy), 32'(tl[i].busy));
      chk("pidx", 32'(pulse_idx), 32'(tl[i].idx));
      chk("done", 32'(done), 32'(tl[i].done));
      chk("spk", 32'(spike_count), 32'(cnt));
      chk("ready_run", 32'(cfg_ready), 32'd0);
      lidx = tl[i].idx;
      spike_in = mode == 1 ? ~spike_in : 1'($urandom % 2);
      if (tl[i].busy && spike_in && !prev && cnt < 255) cnt++;
      prev = spike_in;
      start = ($urandom % 4) == 0;
      cfg_valid = ($urandom % 4) == 0;
      cfg_addr = 2'($urandom);
      cfg_data = 8'($urandom);
      if (i == abort_at && tl[i].busy) begin
        abort = 1'b1;
        tick;
        abort = 1'b0;
        break;
      end
      tick;
    end
    start = 1'b0;
    cfg_valid = 1'b0;
    idle_chk(lidx, cnt, "end");
  endtask

  initial begin
    tick;
    tick;
    rst_n = 1'b1;
    idle_chk(8'd0, 0, "rst");
    wr(2'd0, 8'h50); wr(2'd1, 8'd2); wr(2'd2, 8'd3); wr(2'd3, 8'd2);
    run(0, -1);
    run(0, 4);
    run(0, -1);
    run(0, -1);
    wr(2'd3, 8'd0);
    run(0, -1);
    wr(2'd3, 8'd2); wr(2'd1, 8'd0);
    run(0, -1);
    wr(2'd0, 8'h77); wr(2'd1, 8'd1); wr(2'd2, 8'd0); wr(2'd3, 8'd3);
    run(0, -1);
    wr(2'd1, 8'd200); wr(2'd3, 8'd1);
    run(1, -1);
    for (int r = 0; r < 25; r++) begin
      wr(2'd0, 8'($urandom));
      wr(2'd1, 8'($urandom_range(0, 3)));
      wr(2'd2, 8'($urandom_range(0, 3)));
      wr(2'd3, 8'($urandom_range(0, 3)));
      run(0, ($urandom % 3) == 0 ? int'($urandom_range(0, 30)) : -1);
    end
    wr(2'd0, 8'h33); wr(2'd1, 8'd1); wr(2'd2, 8'd0); wr(2'd3, 8'd3);
    start = 1'b1;
    tick;
    start = 1'b0;
    for (int i = 0; i < 9; i++) begin
      spike_in = ~spike_in;
      tick;
    end
    chk("pre_rst_pidx", 32'(pulse_idx), 32'd2);
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    spike_in = 1'b0;
    m_amp = '0; m_on = '0; m_off = '0; m_n = '0;
    idle_chk(8'd0, 0, "midrst");
    run(0, -1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
